// File: rtl/fnd_pkg.sv
// Shared codes, page/mode encodings and digit helpers for the DHT11 FND display path.
package fnd_pkg;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        PG_RH   = 2'd0,
        PG_TEMP = 2'd1,
        PG_COMB = 2'd2,
        PG_DASH = 2'd3
    } page_t;

    typedef enum logic [1:0] {
        MODE_AUTO = 2'b00,
        MODE_RH   = 2'b01,
        MODE_TEMP = 2'b10,
        MODE_COMB = 2'b11
    } mode_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } digits_t;

    // Readings above 99 saturate so two digits always suffice.
    function automatic digits_t to_digits(input logic [7:0] v);
        logic [6:0] s;
        digits_t    d;
        s      = (v > 8'd99) ? 7'd99 : v[6:0];
        d.tens = 4'(s / 7'd10);
        d.ones = 4'(s % 7'd10);
        return d;
    endfunction

    function automatic logic [3:0] blank_lz(input logic [3:0] d);
        return (d == 4'd0) ? CODE_BLANK : d;
    endfunction

endpackage

// File: rtl/fnd_scan_timer.sv
// Digit-slot timer: slot counter, leading blank window and 0..3 digit index.
module fnd_scan_timer #(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLANK_CYC = 5_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx,
    output logic       blank,
    output logic       frame_wrap
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] slot_cnt;
    logic          slot_end;

    assign slot_end   = (slot_cnt == CW'(SCAN_DIV - 1));
    assign blank      = (slot_cnt < CW'(BLANK_CYC));
    assign frame_wrap = slot_end && (idx == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
            idx      <= 2'd0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fnd_page_scheduler.sv
// Page scheduler for the 4-digit FND: sample handshake, err/stale/dwell tracking,
// frame-synchronous page FSM and registered digit scan outputs.
module fnd_page_scheduler
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYC    = 5_000,
    parameter int PAGE_FRAMES  = 500,
    parameter int STALE_FRAMES = 1_250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rh_data,
    input  logic [7:0] temp_data,
    input  logic       data_valid,
    input  logic       sensor_err,
    input  logic [1:0] mode,
    output logic [3:0] fnd_com,
    output logic [3:0] bcd,
    output logic       fnd_dp,
    output logic       frame_start,
    output logic [1:0] page
);

    localparam int SW = $clog2(STALE_FRAMES + 1);
    localparam int DW = $clog2(PAGE_FRAMES + 1);

    logic [1:0]    idx;
    logic          blank;
    logic          frame_wrap;

    logic [7:0]    pend_rh, pend_temp, disp_rh, disp_temp;
    logic          pend, no_data, err;
    logic          no_data_nxt, err_nxt, apply_sample;
    logic [SW-1:0] stale_cnt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic          rot_temp, rot_nxt;
    logic [1:0]    mode_q;
    logic          wrap_d;

    page_t         page_q, page_nxt;
    logic          show_err_q, show_err_nxt;

    digits_t       rh_dig, temp_dig, val_dig;
    logic [3:0]    digit_code;
    logic          digit_dp;

    fnd_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .blank      (blank),
        .frame_wrap (frame_wrap)
    );

    // An error pulse discards any pending sample, so a pending sample is always newer than err.
    assign apply_sample = frame_wrap && pend && !sensor_err;
    assign err_nxt      = sensor_err || (err && !apply_sample);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        no_data_nxt = no_data;
        if (apply_sample) begin
            no_data_nxt = 1'b0;
        end else if (frame_wrap && (stale_cnt >= SW'(STALE_FRAMES - 1))) begin
            no_data_nxt = 1'b1;
        end
    end

    always_comb begin
        dwell_nxt = dwell_cnt + DW'(1);
        rot_nxt   = rot_temp;
        if (mode != mode_q) begin
            dwell_nxt = '0;
            rot_nxt   = 1'b0;
        end else if (dwell_cnt == DW'(PAGE_FRAMES - 1)) begin
            dwell_nxt = '0;
            rot_nxt   = ~rot_temp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_rh   <= '0;
            pend_temp <= '0;
            disp_rh   <= '0;
            disp_temp <= '0;
            pend      <= 1'b0;
            no_data   <= 1'b1;
            err       <= 1'b0;
            stale_cnt <= '0;
            dwell_cnt <= '0;
            rot_temp  <= 1'b0;
            mode_q    <= MODE_AUTO;
        end else begin
            err     <= err_nxt;
            no_data <= no_data_nxt;

            if (sensor_err) begin
                pend <= 1'b0;
            end else if (data_valid) begin
                pend      <= 1'b1;
                pend_rh   <= rh_data;
                pend_temp <= temp_data;
            end else if (apply_sample) begin
                pend <= 1'b0;
            end

            if (frame_wrap) begin
                if (apply_sample) begin
                    disp_rh   <= pend_rh;
                    disp_temp <= pend_temp;
                    stale_cnt <= '0;
                end else if (stale_cnt != SW'(STALE_FRAMES)) begin
                    stale_cnt <= stale_cnt + SW'(1);
                end
                mode_q    <= mode;
                dwell_cnt <= dwell_nxt;
                rot_temp  <= rot_nxt;
            end
        end
    end

    // Page FSM: only moves on the frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_q     <= PG_DASH;
            show_err_q <= 1'b0;
        end else begin
            page_q     <= page_nxt;
            show_err_q <= show_err_nxt;
        end
    end

    always_comb begin
        page_nxt     = page_q;
        show_err_nxt = show_err_q;
        if (frame_wrap) begin
            show_err_nxt = err_nxt;
            if (err_nxt || no_data_nxt) begin
                page_nxt = PG_DASH;
            end else begin
                unique case (mode)
                    MODE_AUTO: page_nxt = rot_nxt ? PG_TEMP : PG_RH;
                    MODE_RH:   page_nxt = PG_RH;
                    MODE_TEMP: page_nxt = PG_TEMP;
                    default:   page_nxt = PG_COMB;
                endcase
            end
        end
    end

    assign rh_dig   = to_digits(disp_rh);
    assign temp_dig = to_digits(disp_temp);
    assign val_dig  = (page_q == PG_TEMP) ? temp_dig : rh_dig;

    always_comb begin
        digit_code = CODE_BLANK;
        digit_dp   = 1'b0;
        unique case (page_q)
            PG_RH, PG_TEMP: begin
                case (idx)
                    2'd0:    digit_code = val_dig.ones;
                    2'd1:    digit_code = blank_lz(val_dig.tens);
                    default: digit_code = CODE_BLANK;
                endcase
                digit_dp = (page_q == PG_RH) ? (idx == 2'd3) : (idx == 2'd2);
            end
            PG_COMB: begin
                case (idx)
                    2'd0:    digit_code = temp_dig.ones;
                    2'd1:    digit_code = temp_dig.tens;
                    2'd2:    digit_code = rh_dig.ones;
                    default: digit_code = rh_dig.tens;
                endcase
                digit_dp = (idx == 2'd2);
            end
            default: digit_code = show_err_q ? CODE_E : CODE_DASH;
        endcase
    end

    // Outputs are a registered image of the current scan position, so they trail the counters by one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fnd_com     <= 4'b1111;
            bcd         <= CODE_BLANK;
            fnd_dp      <= 1'b0;
            frame_start <= 1'b0;
            page        <= PG_DASH;
            wrap_d      <= 1'b0;
        end else begin
            wrap_d      <= frame_wrap;
            frame_start <= wrap_d;
            page        <= page_q;
            if (blank) begin
                fnd_com <= 4'b1111;
                bcd     <= CODE_BLANK;
                fnd_dp  <= 1'b0;
            end else begin
                fnd_com <= ~(4'b0001 << idx);
                bcd     <= digit_code;
                fnd_dp  <= digit_dp;
            end
        end
    end

endmodule

// File: tb/tb_fnd_page_scheduler.sv
// Self-checking bench for fnd_page_scheduler: directed scenarios plus random traffic,
// every output compared each cycle against a frame-level reference model.
module tb_fnd_page_scheduler;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int PF    = 3;
    localparam int SF    = 6;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rh_data;
    logic [7:0] temp_data;
    logic       data_valid;
    logic       sensor_err;
    logic [1:0] mode;
    logic [3:0] fnd_com;
    logic [3:0] bcd;
    logic       fnd_dp;
    logic       frame_start;
    logic [1:0] page;

    fnd_page_scheduler #(
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .PAGE_FRAMES  (PF),
        .STALE_FRAMES (SF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rh_data     (rh_data),
        .temp_data   (temp_data),
        .data_valid  (data_valid),
        .sensor_err  (sensor_err),
        .mode        (mode),
        .fnd_com     (fnd_com),
        .bcd         (bcd),
        .fnd_dp      (fnd_dp),
        .frame_start (frame_start),
        .page        (page)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k      = 0;   // clocks since reset release

    // Reference model state: pending sample, flags and what each frame shows.
    bit m_pend, m_err, m_no_data;
    int m_stale, m_prh, m_ptp, m_drh, m_dtp, m_mode_q, m_change;
    int nx_page, nx_rh, nx_tp, sh_page, sh_rh, sh_tp;
    bit nx_err, sh_err;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    // Expected code for digit d (0 = rightmost) of a frame showing page pg.
    function automatic logic [3:0] exp_digit(input int pg, input bit er, input int rh, input int tp, input int d);
        logic [3:0] digs [4];
        int r, t, v;
        r = sat(rh);
        t = sat(tp);
        v = (pg == 1) ? t : r;
        case (pg)
            0, 1: begin
                digs[3] = 4'hF;
                digs[2] = 4'hF;
                digs[1] = (v / 10 == 0) ? 4'hF : 4'(v / 10);
                digs[0] = 4'(v % 10);
            end
            2: begin
                digs[3] = 4'(r / 10);
                digs[2] = 4'(r % 10);
                digs[1] = 4'(t / 10);
                digs[0] = 4'(t % 10);
            end
            default: for (int i = 0; i < 4; i++) digs[i] = er ? 4'hE : 4'hA;
        endcase
        return digs[d];
    endfunction

    function automatic int dp_pos(input int pg);
        case (pg)
            0:       return 3;
            1, 2:    return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_err = 0; m_no_data = 1; m_stale = 0;
        m_prh = 0; m_ptp = 0; m_drh = 0; m_dtp = 0;
        m_mode_q = 0; m_change = 0;
        nx_page = 3; nx_err = 0; nx_rh = 0; nx_tp = 0;
        sh_page = 3; sh_err = 0; sh_rh = 0; sh_tp = 0;
    endtask

    task automatic model_boundary();
        int f;
        f = k / FRAME;
        if (m_pend) begin
            m_drh = m_prh; m_dtp = m_ptp;
            m_pend = 0; m_err = 0; m_no_data = 0; m_stale = 0;
        end else begin
            if (m_stale < SF) m_stale++;
            if (m_stale >= SF) m_no_data = 1;
        end
        if (int'(mode) != m_mode_q) begin
            m_mode_q = int'(mode);
            m_change = f;
        end
        nx_err = m_err; nx_rh = m_drh; nx_tp = m_dtp;
        if (m_err || m_no_data) nx_page = 3;
        else case (int'(mode))
            0:       nx_page = (((f - m_change) / PF) % 2 == 1) ? 1 : 0;
            1:       nx_page = 0;
            2:       nx_page = 1;
            default: nx_page = 2;
        endcase
    endtask

    task automatic check_outputs();
        int p, slot, c;
        logic [3:0] e_com, e_bcd;
        logic e_dp, e_fs;
        e_com = 4'hF; e_bcd = 4'hF; e_dp = 1'b0; e_fs = 1'b0;
        if (k > 0) begin
            p    = (k - 1) % FRAME;
            slot = p / SD;
            c    = p % SD;
            e_fs = (p == 0) && (k > 1);
            if (c >= BC) begin
                e_com[slot] = 1'b0;
                e_bcd = exp_digit(sh_page, sh_err, sh_rh, sh_tp, slot);
                e_dp  = (dp_pos(sh_page) == slot);
            end
        end
        check("fnd_com", fnd_com, e_com);
        check("bcd", bcd, e_bcd);
        check("fnd_dp", {3'b000, fnd_dp}, {3'b000, e_dp});
        check("frame_start", {3'b000, frame_start}, {3'b000, e_fs});
        check("page", {2'b00, page}, 4'(sh_page));
    endtask

    task automatic advance();
        @(posedge clk);
        k++;
        if (k % FRAME == 0) model_boundary();
        if (k > 1 && (k - 1) % FRAME == 0) begin
            sh_page = nx_page; sh_err = nx_err; sh_rh = nx_rh; sh_tp = nx_tp;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) advance();
    endtask

    // Single-cycle input pulse placed mid-frame, away from any boundary clock.
    task automatic pulse(input bit v, input bit e, input int r, input int t);
        while ((k % FRAME) < 8 || (k % FRAME) > 24) advance();
        data_valid = v;
        sensor_err = e;
        rh_data    = 8'(r);
        temp_data  = 8'(t);
        if (e) begin
            m_err = 1; m_pend = 0;
        end else if (v) begin
            m_pend = 1; m_prh = r; m_ptp = t;
        end
        advance();
        data_valid = 1'b0;
        sensor_err = 1'b0;
    endtask

    initial begin
        int sel;
        rst = 1'b0; data_valid = 1'b0; sensor_err = 1'b0;
        rh_data = 8'd0; temp_data = 8'd0; mode = 2'b00;
        model_reset();

        // Reset state, then idle release: blank/blank/digit-on and dashes.
        repeat (2) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b1;
        run(FRAME + 8);

        // Combined page with a sample arriving mid-frame.
        mode = 2'b11;
        pulse(1, 0, 45, 23);
        run(2 * FRAME);

        // Auto-rotate with refreshes every two frames; small values exercise blanking.
        mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            pulse(1, 0, (i % 2 == 0) ? 60 : 5, 7);
            run(2 * FRAME - 1);
        end

        // Saturation, then silence until the data goes stale.
        mode = 2'b01;
        pulse(1, 0, 120, 88);
        run(9 * FRAME);

        // Error and valid together, then a clean sample restores the page.
        mode = 2'b10;
        pulse(1, 1, 33, 44);
        run(2 * FRAME);
        pulse(1, 0, 12, 34);
        run(2 * FRAME);

        // Random traffic and mode changes.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel <= 5)      pulse(1, 0, $urandom_range(0, 255), $urandom_range(0, 255));
            else if (sel == 6) pulse(0, 1, 0, 0);
            else if (sel == 7) pulse(1, 1, $urandom_range(0, 255), $urandom_range(0, 255));
            run($urandom_range(5, 60));
        end

        // Asynchronous reset in the middle of a lit digit.
        while (k == 0 || ((k - 1) % SD) != 5) advance();
        #2 rst = 1'b0;
        #1;
        check("rst_async_com", fnd_com, 4'hF);
        check("rst_async_bcd", bcd, 4'hF);
        model_reset();
        k = 0;
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 1'b1;
        run(2 * FRAME + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_page_scheduler.md
# fnd_page_scheduler

Display scheduler for the 4-digit FND on the DHT11 humidity/temperature board. It takes the sensor's humidity and temperature bytes and error pulses and decides which page is shown: RH, TEMP, combined, dash/no-data or error. It produces the multiplexed digit scan with a blanking gap between digits, and updates data and pages only at frame boundaries so no frame is ever torn. It sits between the DHT11 receiver and the segment decoder, and replaces the free-running divider/counter/mux scan path.

## Interface
- SCAN_DIV, 100_000: clocks per digit slot (1 kHz slot rate at 100 MHz).
- BLANK_CYC, 5_000: clocks at the start of each slot with all digits off. Must satisfy 1 ≤ BLANK_CYC < SCAN_DIV.
- PAGE_FRAMES, 500: frames per page in auto-rotate mode (one frame = 4 slots).
- STALE_FRAMES, 1_250: frames with no data_valid before the data is declared stale.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rh_data  in  8  humidity byte, qualified by data_valid.
- temp_data  in  8  temperature byte, qualified by data_valid.
- data_valid  in  1  single-cycle pulse: a new sample is present.
- sensor_err  in  1  single-cycle pulse: checksum or timeout failure.
- mode  in  2  display mode:
  - 00 auto-rotate RH↔TEMP
  - 01 RH only
  - 10 TEMP only
  - 11 combined
- fnd_com  out  4  digit enables, active-low; bit 0 is the rightmost digit.
- bcd  out  4  digit code: 0–9 digits, 4'hA dash, 4'hE letter E, 4'hF blank.
- fnd_dp  out  1  decimal point, active-high; the downstream decoder inverts it.
- frame_start  out  1  one-cycle pulse on the first clock of slot 0.
- page  out  2  current page: 0 RH, 1 TEMP, 2 COMB, 3 DASH/ERR.

## Operation
- Reset values:
  - fnd_com=4'b1111, bcd=4'hF, fnd_dp=0, frame_start=0, page=3.
  - Data registers 0. `no_data`=1, `err`=0, all counters 0.
- Scan: the slot counter runs 0..SCAN_DIV-1 and the digit index runs 0→1→2→3→0.
  - Slot cycles 0..BLANK_CYC-1: fnd_com=1111, bcd=F.
  - Remaining cycles: fnd_com=~(1<<idx), and bcd/fnd_dp carry that digit's code.
- Frame boundary: the clock where idx wraps 3→0. Every page, data or mode update is applied here and nowhere else.
- Data handshake:
  - data_valid latches rh/temp into pending registers and sets `pend`.
  - At the boundary, pending is copied to display, then `pend`, `no_data`, `err` and the stale counter are cleared.
  - A second valid before the boundary overwrites pending.
- sensor_err sets `err`, which is sticky until a later data_valid is applied. If err and valid arrive in the same cycle, err wins and the sample is discarded.
- Staleness: the stale counter increments each frame and saturates at STALE_FRAMES. Reaching STALE_FRAMES sets `no_data`.
- Page selection at each boundary, in priority order:
  1. err → ERR page: E E E E.
  2. no_data → DASH page: A A A A.
  3. Otherwise by mode. For mode 00, the dwell counter toggles RH↔TEMP every PAGE_FRAMES frames, starting with RH.
- Any change in mode clears the dwell counter at the next boundary.
- Digit content, listed digit 3..0:
  - RH: F F tens ones, with dp on digit 3.
  - TEMP: F F tens ones, with dp on digit 2.
  - COMB: rh-tens rh-ones temp-tens temp-ones, with dp on digit 2.
- Arithmetic: values above 99 saturate to 99. tens = v/10 and ones = v%10 on the 7-bit saturated value. A tens digit of 0 is shown as F (leading-zero blank), except in COMB where 0 is shown as 0.

## Timing
- All outputs are registered and driven from the counters; there are no combinational input-to-output paths.
- Slot period = SCAN_DIV clocks exactly. Frame period = 4·SCAN_DIV clocks.
- data_valid latency: the value is visible in the first digit-on cycle of the frame after the next boundary. It is never shown mid-frame.
- frame_start is asserted in the same cycle that the page and data are updated.
- A reset asserted mid-frame forces the reset values immediately (asynchronous). The scan restarts at slot 0, idx 0 on the first clock after release.

## Structure
- Package fnd_pkg holds:
  - code constants: CODE_DASH=4'hA, CODE_E=4'hE, CODE_BLANK=4'hF
  - the page enum (PG_RH, PG_TEMP, PG_COMB, PG_DASH)
  - the mode encodings
- Sub-module fnd_scan_timer contains the slot counter, blank window and digit index. It outputs `idx`, `blank` and `frame_wrap`.
- The top level holds the handshake/pending registers, the err/stale/dwell logic, the page FSM and the digit encode.

## Test plan
Run with SCAN_DIV=8, BLANK_CYC=2, PAGE_FRAMES=3, STALE_FRAMES=6.
- Reset, then release with no input → fnd_com pattern 1111 for 2 clocks, then 1110; bcd=A on every digit; page=3.
- data_valid with rh=45, temp=23 in mid-frame, mode 11 → from the next frame start, digits 3..0 = 4,5,2,3, dp on digit 2, page=2. The current frame is unchanged.
- Mode 00 with valid data refreshed every 2 frames → page sequence RH×3 frames, TEMP×3, RH…; temp=7 is shown as F F F 7.
- rh=120 → shown as 9,9; no data_valid for 6 frames → DASH page at the 6th boundary.
- sensor_err and data_valid in the same cycle → ERR page (E E E E) from the next frame. A later valid returns the display to the data page.
- Assert rst mid-slot during a digit-on window → fnd_com=1111 and bcd=F in the same cycle. After release, frame_start fires 4·SCAN_DIV clocks later.
